// File: rtl/hex_ascii_streamer.sv
// Purpose : converts one WIDTH-bit word into a stream of ASCII hex characters, MS digit first,
//           with an optional "0x" prefix and selectable letter case.
// Latency : first character is registered and valid 1 cycle after the input accept edge.
// Backpr. : in_ready only in IDLE; out_char/out_last/out_valid hold stable while out_ready=0.
//
// Ports   : clk, rst_n (sync, active-low); in_valid/in_ready/in_data word input;
//           out_valid/out_ready/out_char/out_last character output (out_last marks final digit).
// Option  : define HEX_ASCII_ZERO_SUPPRESS_EN to start at the most significant nonzero nibble
//           (a zero word yields a single '0'); otherwise all NDIG digits are emitted.
module hex_ascii_streamer #(
    parameter int WIDTH  = 32,
    parameter bit UPPER  = 1'b0,
    parameter bit PREFIX = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_char,
    output logic             out_last
);

    localparam int NDIG  = (WIDTH + 3) / 4;
    localparam int NBITS = 4 * NDIG;
    localparam int IDXW  = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PFX0  = 2'd1,
        PFX1  = 2'd2,
        DIGIT = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [NBITS-1:0]  word_q, word_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [7:0]        out_char_q, out_char_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;

    logic [NBITS-1:0]  word_ext;
    logic [IDXW-1:0]   first_idx;
    logic [3:0]        nib;
    logic              xfer;

    assign xfer      = out_valid_q && out_ready;
    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_char  = out_char_q;
    assign out_last  = out_last_q;

    // Zero-extend the input to a whole number of nibbles.
    always_comb begin
        word_ext              = '0;
        word_ext[WIDTH-1:0]   = in_data;
    end

    // Index of the first digit to emit for the word being accepted.
`ifdef HEX_ASCII_ZERO_SUPPRESS_EN
    always_comb begin
        first_idx = '0;
        // Ascending scan: the highest nonzero nibble is the last one to win.
        for (int i = 0; i < NDIG; i++) begin
            if (word_ext[i*4 +: 4] != 4'h0) begin
                first_idx = IDXW'(i);
            end
        end
    end
`else
    always_comb begin
        first_idx = IDXW'(NDIG - 1);
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            word_q      <= '0;
            idx_q       <= '0;
            out_char_q  <= 8'h00;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            idx_q       <= idx_d;
            out_char_q  <= out_char_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    word_d  = word_ext;
                    idx_d   = first_idx;
                    state_d = PREFIX ? PFX0 : DIGIT;
                end
            end
            PFX0: begin
                if (xfer) begin
                    state_d = PFX1;
                end
            end
            PFX1: begin
                if (xfer) begin
                    state_d = DIGIT;
                end
            end
            DIGIT: begin
                if (xfer) begin
                    if (idx_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q - IDXW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: computed from the next state so the registered outputs
    // present the character of the state being entered.
    always_comb begin
        nib = 4'h0;
        for (int i = 0; i < NDIG; i++) begin
            if (idx_d == IDXW'(i)) begin
                nib = word_d[i*4 +: 4];
            end
        end

        out_char_d  = 8'h00;
        out_valid_d = (state_d != IDLE);
        out_last_d  = (state_d == DIGIT) && (idx_d == '0);
        case (state_d)
            PFX0:  out_char_d = 8'd48;
            PFX1:  out_char_d = 8'd120;
            DIGIT: begin
                if (nib < 4'd10) begin
                    out_char_d = 8'd48 + {4'h0, nib};
                end else begin
                    // 'A'-10 = 55, 'a'-10 = 87
                    out_char_d = (UPPER ? 8'd55 : 8'd87) + {4'h0, nib};
                end
            end
            default: out_char_d = 8'h00;
        endcase
    end

endmodule
